key_schedule: RTL and testbench

- Sequential AES-128 key expansion controller.
- Loads a 128-bit cipher key and iterates the existing combinational round-key core (ke_core) once per clock to produce round keys 1..10.
- Stores all 11 round keys (round 0 = cipher key) in an internal register file.
- Serves the round keys to the downstream cipher datapath through a registered read port.
- Sits between the host key-load interface and the round datapath.

---
 rtl/key_schedule_pkg.sv | 62 ++++++
 rtl/ke_core.sv | 52 +++++
 rtl/rcon.sv | 34 +++
 rtl/sbox.sv | 20 ++
 rtl/key_schedule.sv | 152 +++++++++++++++
 tb/tb_key_schedule.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/key_schedule_pkg.sv
// -----------------------------------------------------------------------------
// key_schedule_pkg
// Shared definitions for the AES-128 key expansion slice:
//   - AES-128 sizing constants (rounds, key width, read-address width)
//   - FSM state encoding for the key_schedule controller
//   - GF(2^8) helper functions used by the S-box
// -----------------------------------------------------------------------------
package key_schedule_pkg;

    localparam int KS_NR       = 10;          // expansion rounds
    localparam int KS_KW       = 128;         // key / round-key width
    localparam int KS_AW       = 4;           // round-key read-address width
    localparam int KS_RK_COUNT = KS_NR + 1;   // stored round keys (0..NR)

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] v_p;
        logic [7:0] v_a;
        logic [7:0] v_b;
        v_p = 8'h00;
        v_a = a;
        v_b = b;
        for (int i = 0; i < 8; i++) begin
            if (v_b[0]) v_p = v_p ^ v_a;
            v_a = v_a[7] ? ({v_a[6:0], 1'b0} ^ 8'h1b) : {v_a[6:0], 1'b0};
            v_b = {1'b0, v_b[7:1]};
        end
        return v_p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] v_sq;
        logic [7:0] v_res;
        v_sq  = x;
        v_res = 8'h01;
        for (int k = 1; k < 8; k++) begin
            v_sq  = gf_mul(v_sq, v_sq);
            v_res = gf_mul(v_res, v_sq);
        end
        return v_res;
    endfunction

    // AES affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    function automatic logic [7:0] sbox_affine(input logic [7:0] b);
        logic [7:0] v_r1;
        logic [7:0] v_r2;
        logic [7:0] v_r3;
        logic [7:0] v_r4;
        v_r1 = {b[6:0], b[7]};
        v_r2 = {b[5:0], b[7:6]};
        v_r3 = {b[4:0], b[7:5]};
        v_r4 = {b[3:0], b[7:4]};
        return b ^ v_r1 ^ v_r2 ^ v_r3 ^ v_r4 ^ 8'h63;
    endfunction

endpackage

// File: rtl/ke_core.sv
// -----------------------------------------------------------------------------
// ke_core
// Combinational AES-128 single-round key expansion: given round key i-1 and
// the round index i, produces round key i.
// Ports:
//   i_key    in  KS_KW  previous round key, bits [127:96] = word w0
//   i_round  in  KS_AW  round index i (1..10)
//   o_key    out KS_KW  next round key
// -----------------------------------------------------------------------------
module ke_core
    import key_schedule_pkg::*;
(
    input  logic [KS_KW-1:0] i_key,
    input  logic [KS_AW-1:0] i_round,
    output logic [KS_KW-1:0] o_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_temp;
    logic [7:0]  w_rcon;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = i_key;

    // RotWord: [a0,a1,a2,a3] -> [a1,a2,a3,a0] with a0 as the top byte.
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    rcon u_rcon (
        .i_round (i_round),
        .o_rcon  (w_rcon)
    );

    assign w_temp = w_sub ^ {w_rcon, 24'h000000};

    // Each new word chains off the one just produced.
    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/rcon.sv
// -----------------------------------------------------------------------------
// rcon
// AES round constant lookup. Round 1 -> 0x01 ... round 10 -> 0x36;
// any other index returns 0.
// Ports:
//   i_round  in  KS_AW  round index
//   o_rcon   out 8      round constant byte
// -----------------------------------------------------------------------------
module rcon
    import key_schedule_pkg::*;
(
    input  logic [KS_AW-1:0] i_round,
    output logic [7:0]       o_rcon
);

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no latch is inferred.
        o_rcon = 8'h00;
        case (i_round)
            4'd1:    o_rcon = 8'h01;
            4'd2:    o_rcon = 8'h02;
            4'd3:    o_rcon = 8'h04;
            4'd4:    o_rcon = 8'h08;
            4'd5:    o_rcon = 8'h10;
            4'd6:    o_rcon = 8'h20;
            4'd7:    o_rcon = 8'h40;
            4'd8:    o_rcon = 8'h80;
            4'd9:    o_rcon = 8'h1b;
            4'd10:   o_rcon = 8'h36;
            default: o_rcon = 8'h00;
        endcase
    end

endmodule

// File: rtl/sbox.sv
// -----------------------------------------------------------------------------
// sbox
// Combinational AES forward S-box, computed as inverse-then-affine.
// Ports:
//   i_byte  in  8  input byte
//   o_byte  out 8  substituted byte
// -----------------------------------------------------------------------------
module sbox
    import key_schedule_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = sbox_affine(w_inv);

endmodule

// File: rtl/key_schedule.sv
// -----------------------------------------------------------------------------
// key_schedule
// Sequential AES-128 key expansion controller. Captures a cipher key on start,
// runs ke_core once per clock to fill round keys 1..NR, and serves any stored
// round key through a registered read port.
// Ports:
//   clk        in  1   system clock
//   rst        in  1   synchronous active-high reset
//   start      in  1   expansion request, honoured only in IDLE
//   key_in     in  KW  cipher key (w0 in bits [127:96])
//   busy       out 1   expansion in progress
//   done       out 1   one-cycle pulse after round key NR is written
//   key_valid  out 1   register file holds a complete schedule
//   rk_addr    in  AW  round-key read index 0..NR
//   rk_data    out KW  round key at rk_addr, one cycle later; 0 if out of range
// -----------------------------------------------------------------------------
module key_schedule
    import key_schedule_pkg::*;
#(
    parameter int NR = KS_NR,
    parameter int KW = KS_KW,
    parameter int AW = KS_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          done,
    output logic          key_valid,
    input  logic [AW-1:0] rk_addr,
    output logic [KW-1:0] rk_data
);

    localparam logic [AW-1:0] LP_LAST = AW'(NR);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_round;
    logic [AW-1:0] w_next_round;
    logic          r_busy;
    logic          w_next_busy;
    logic          r_done;
    logic          w_next_done;
    logic          r_key_valid;
    logic          w_next_key_valid;
    logic          w_load;
    logic          w_expand;

    logic [KW-1:0] r_rk [NR+1];
    logic [KW-1:0] r_rk_data;
    logic [KW-1:0] w_prev_key;
    logic [KW-1:0] w_core_key;
    logic [KW-1:0] w_rd_key;

    // Feed for the single ke_core: rk[round-1]. Round 0 never expands, so
    // it simply selects nothing.
    always_comb begin
        w_prev_key = '0;
        for (int i = 0; i < NR; i++) begin
            if (r_round == AW'(i + 1)) w_prev_key = r_rk[i];
        end
    end

    ke_core u_ke_core (
        .i_key   (w_prev_key),
        .i_round (KS_AW'(r_round)),
        .o_key   (w_core_key)
    );

    // Read mux; addresses beyond NR match no entry and return zero.
    always_comb begin
        w_rd_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rk_addr == AW'(i)) w_rd_key = r_rk[i];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_next_state     = r_state;
        w_next_round     = r_round;
        w_next_busy      = r_busy;
        w_next_done      = 1'b0;
        w_next_key_valid = r_key_valid;
        w_load           = 1'b0;
        w_expand         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load           = 1'b1;
                    w_next_state     = ST_EXPAND;
                    w_next_round     = AW'(1);
                    w_next_busy      = 1'b1;
                    w_next_key_valid = 1'b0;
                end
            end
            ST_EXPAND: begin
                w_expand = 1'b1;
                if (r_round == LP_LAST) begin
                    w_next_state     = ST_IDLE;
                    w_next_round     = '0;
                    w_next_busy      = 1'b0;
                    w_next_done      = 1'b1;
                    w_next_key_valid = 1'b1;
                end else begin
                    w_next_round = r_round + AW'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Control state and registered read port.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_round     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_key_valid <= 1'b0;
            r_rk_data   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_round     <= w_next_round;
            r_busy      <= w_next_busy;
            r_done      <= w_next_done;
            r_key_valid <= w_next_key_valid;
            r_rk_data   <= w_rd_key;
        end
    end

    // Round-key register file.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; key_valid qualifies its contents, and writes are blocked while rst is high.
        if (!rst) begin
            if (w_load) r_rk[0] <= key_in;
            for (int i = 1; i <= NR; i++) begin
                if (w_expand && (r_round == AW'(i))) r_rk[i] <= w_core_key;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign key_valid = r_key_valid;
    assign rk_data   = r_rk_data;

endmodule

// File: tb/tb_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_key_schedule
// Self-checking bench for key_schedule. A reference key expansion computed
// straight from the AES definition (brute-force field inverse, word-wise
// expansion loop) supplies expected round keys; directed steps cover the
// handshake, back-to-back, reset and out-of-range read cases.
// -----------------------------------------------------------------------------
module tb_key_schedule;

    localparam int NR = 10;
    localparam int KW = 128;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] key_in;
    logic          busy;
    logic          done;
    logic          key_valid;
    logic [AW-1:0] rk_addr;
    logic [KW-1:0] rk_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    sbox_tab [256];
    logic [KW-1:0] exp_rk   [NR+1];

    key_schedule #(.NR(NR), .KW(KW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            sbox_tab[x] = s;
        end
    endtask

    task automatic expand_model(input logic [KW-1:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = ref_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic b, input logic d, input logic v);
        check(tag, KW'({busy, done, key_valid}), KW'({b, d, v}));
    endtask

    function automatic logic [KW-1:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Pulse start for one edge; key_in is scrambled afterwards to prove it is
    // captured only at the start edge.
    task automatic start_pulse(input string tag, input logic [KW-1:0] key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = rand_key();
        check_status({tag, "_accept"}, 1'b1, 1'b0, 1'b0);
    endtask

    // Walks cycles 2..11 after the start edge; busy must hold through cycle
    // 10 and done/key_valid must appear in cycle 11. Optionally fires an
    // extra start mid-expansion that must be ignored.
    task automatic run_to_done(input string tag, input int inject_cycle, input logic [KW-1:0] inject_key);
        for (int c = 2; c <= NR + 1; c++) begin
            if (c == inject_cycle) begin
                start  = 1'b1;
                key_in = inject_key;
            end
            tick();
            start = 1'b0;
            if (c <= NR) check_status($sformatf("%s_busy_c%0d", tag, c), 1'b1, 1'b0, 1'b0);
            else         check_status($sformatf("%s_done_c%0d", tag, c), 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic check_schedule(input string tag);
        for (int a = 0; a <= NR; a++) begin
            rk_addr = AW'(a);
            tick();
            check($sformatf("%s_rk%0d", tag, a), rk_data, exp_rk[a]);
        end
    endtask

    task automatic read_const(input string tag, input int a, input logic [KW-1:0] exp);
        rk_addr = AW'(a);
        tick();
        check(tag, rk_data, exp);
    endtask

    // ---------------- directed sequence ----------------
    logic [KW-1:0] fips_key;
    logic [KW-1:0] rkey;

    initial begin
        build_sbox();
        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

        // Reset held for 3 cycles with start asserted: nothing may move.
        rst     = 1'b1;
        start   = 1'b1;
        key_in  = rand_key();
        rk_addr = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_status($sformatf("rst_hold_%0d", i), 1'b0, 1'b0, 1'b0);
            check($sformatf("rst_rkdata_%0d", i), rk_data, '0);
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check_status("post_rst_idle", 1'b0, 1'b0, 1'b0);

        // FIPS-197 A.1 with an ignored start mid-expansion.
        expand_model(fips_key);
        start_pulse("fips", fips_key);
        run_to_done("fips", 4, 128'h000102030405060708090a0b0c0d0e0f);
        tick();
        check_status("fips_done_single", 1'b0, 1'b0, 1'b1);
        check_schedule("fips");
        read_const("fips_rk1_vec", 1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_const("fips_rk10_vec", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_const("fips_rk0_vec", 0, fips_key);

        // Out-of-range reads return zero; last valid index still readable.
        for (int a = NR + 1; a < 16; a++) read_const($sformatf("oor_%0d", a), a, '0);
        read_const("oor_rk10_still", 10, exp_rk[10]);

        // Back-to-back: random key, then zero key started in the done cycle.
        rkey = rand_key();
        expand_model(rkey);
        start_pulse("b2b_first", rkey);
        run_to_done("b2b_first", 0, '0);
        key_in = '0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check_status("b2b_second_accept", 1'b1, 1'b0, 1'b0);
        run_to_done("b2b_second", 0, '0);
        expand_model('0);
        check_schedule("zero");
        read_const("zero_rk10_vec", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Reset in the middle of an expansion.
        rk_addr = AW'(10);
        start_pulse("midrst", rand_key());
        for (int c = 2; c <= 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_status("midrst_status", 1'b0, 1'b0, 1'b0);
        check("midrst_rkdata", rk_data, '0);
        rkey = rand_key();
        expand_model(rkey);
        start_pulse("after_rst", rkey);
        run_to_done("after_rst", 0, '0);
        check_schedule("after_rst");

        // Random keys, with random read traffic during expansion.
        for (int n = 0; n < 3; n++) begin
            rkey = rand_key();
            expand_model(rkey);
            rk_addr = AW'($urandom_range(0, 15));
            start_pulse($sformatf("rnd%0d", n), rkey);
            run_to_done($sformatf("rnd%0d", n), int'($urandom_range(2, 10)), rand_key());
            check_schedule($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
